// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART frame parser.
package uart_pkg;

  typedef enum logic [2:0] {
    S_HUNT,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_DRAIN
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam int         ERR_CNT_W    = 8;
  localparam int         BYTE_W       = 8;

endpackage

// File: rtl/uart_frame_buf.sv
// uart_frame_buf: payload store, one write port, one asynchronous read port.
module uart_frame_buf
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [BYTE_W-1:0] rd_data
);

  logic [BYTE_W-1:0] mem [DEPTH];

  // capture payload bytes as they arrive
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: hunts for SYNC_BYTE, reads LEN, buffers payload, verifies an
// 8-bit additive checksum over the payload bytes, then replays the payload on a
// valid/ready stream. Bad frames are dropped, pulsed on o_err and counted.
// Optional macro UART_FRAME_TIMEOUT_EN adds an inter-byte timeout inside a frame.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1024,
  localparam int        LEN_W          = $clog2(MAX_LEN + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_valid,
  output logic                 o_rx_rdy,
  output logic [7:0]           o_data,
  output logic                 o_valid,
  input  logic                 i_rdy,
  output logic                 o_last,
  output logic [LEN_W-1:0]     o_len,
  output logic                 o_err,
  output logic [ERR_CNT_W-1:0] o_err_count
);

  localparam int               IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);

  state_t                 state, state_n;
  logic [LEN_W-1:0]       len, len_n, idx, idx_n;
  logic [7:0]             sum, sum_n;
  logic                   err, err_n;
  logic [ERR_CNT_W-1:0]   err_cnt;
  logic                   rx_valid_q, rx_rdy;
  logic                   byte_edge, drain, last, wr_en, tmo_hit;
  logic [7:0]             rd_data;

  // i_rx_valid is a level held across the idle gap; only its rising edge is a new byte
  assign byte_edge = i_rx_valid && !rx_valid_q;
  assign drain     = (state == S_DRAIN);
  assign last      = drain && (idx == len - ONE);

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int               TMO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             in_frame;
  assign in_frame = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
  assign tmo_hit  = in_frame && !byte_edge && (tmo_cnt == TMO_MAX);

  // idle-gap counter, only running while a frame is partially received
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || byte_edge || !in_frame || tmo_hit) tmo_cnt <= '0;
    else                                                 tmo_cnt <= tmo_cnt + TMO_W'(1);
  end
`else
  assign tmo_hit = 1'b0;
`endif

  uart_frame_buf #(.DEPTH(MAX_LEN), .AW(IDX_W)) u_buf (
    .clk     (i_clk),
    .wr_en   (wr_en),
    .wr_addr (idx[IDX_W-1:0]),
    .wr_data (i_rx_data),
    .rd_addr (idx[IDX_W-1:0]),
    .rd_data (rd_data)
  );

  // next-state, datapath updates and error detection
  always_comb begin
    state_n = state;
    len_n   = len;
    idx_n   = idx;
    sum_n   = sum;
    err_n   = 1'b0;
    wr_en   = 1'b0;
    case (state)
      S_HUNT: if (byte_edge && i_rx_data == SYNC_BYTE) state_n = S_LEN;
      S_LEN: if (byte_edge) begin
        if (i_rx_data == 8'h00 || i_rx_data > MAX_LEN_B) begin
          err_n   = 1'b1;
          state_n = S_HUNT;
        end else begin
          len_n   = i_rx_data[LEN_W-1:0];
          sum_n   = 8'h00;  // checksum covers payload bytes only
          idx_n   = '0;
          state_n = S_PAYLOAD;
        end
      end
      S_PAYLOAD: if (byte_edge) begin
        wr_en = 1'b1;
        sum_n = sum + i_rx_data;
        idx_n = idx + ONE;
        if (idx == len - ONE) state_n = S_CHK;
      end
      S_CHK: if (byte_edge) begin
        if (i_rx_data == sum) begin
          idx_n   = '0;
          state_n = S_DRAIN;
        end else begin
          err_n   = 1'b1;
          state_n = S_HUNT;
        end
      end
      S_DRAIN: begin
        // receiver ignored o_rx_rdy; the byte is lost but the drain continues
        if (byte_edge) err_n = 1'b1;
        if (i_rdy) begin
          if (last) begin
            idx_n   = '0;
            state_n = S_HUNT;
          end else begin
            idx_n = idx + ONE;
          end
        end
      end
      default: state_n = S_HUNT;
    endcase
    if (tmo_hit) begin
      err_n   = 1'b1;
      state_n = S_HUNT;
    end
  end

  // state and datapath registers; rx_valid_q resets high so a held level is not a byte
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= S_HUNT;
      len        <= '0;
      idx        <= '0;
      sum        <= '0;
      err        <= 1'b0;
      err_cnt    <= '0;
      rx_valid_q <= 1'b1;
      rx_rdy     <= 1'b1;
    end else begin
      state      <= state_n;
      len        <= len_n;
      idx        <= idx_n;
      sum        <= sum_n;
      err        <= err_n;
      rx_valid_q <= i_rx_valid;
      rx_rdy     <= (state_n != S_DRAIN);
      if (err_n && err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

  assign o_rx_rdy    = rx_rdy;
  assign o_valid     = drain;
  assign o_data      = drain ? rd_data : 8'h00;
  assign o_last      = last;
  assign o_len       = len;
  assign o_err       = err;
  assign o_err_count = err_cnt;

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: directed and randomized frames against a frame-level reference.
module tb_uart_frame_parser;
  localparam int         MAX_LEN = 16;
  localparam int         LEN_W   = $clog2(MAX_LEN + 1);
  localparam logic [7:0] SYNC    = 8'hA5;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0]       d;
    logic             l;
    logic [LEN_W-1:0] n;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n, rx_valid, rx_rdy, valid, rdy, last, err;
  logic [7:0]       rx_data, data, err_count;
  logic [LEN_W-1:0] len;
  logic             rdy_fix, rdy_r;
  bit               rdy_rand = 0;

  beat_t rx_q[$];
  int    err_seen;
  int    vectors = 0, miscompares = 0, exp_err = 0;

  always #5 clk = ~clk;

  uart_frame_parser #(.MAX_LEN(MAX_LEN), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(1024)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_rx_rdy(rx_rdy), .o_data(data), .o_valid(valid), .i_rdy(rdy), .o_last(last),
    .o_len(len), .o_err(err), .o_err_count(err_count)
  );

  assign rdy = rdy_rand ? rdy_r : rdy_fix;

  always @(posedge clk) begin
    #1 rdy_r = 1'($urandom_range(0, 1));
  end

  // collect accepted beats and error pulses
  always @(negedge clk) begin
    if (!rst_n) begin
      rx_q.delete();
      err_seen = 0;
    end else begin
      if (valid && rdy) rx_q.push_back('{d: data, l: last, n: len});
      if (err) err_seen++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sum8(input bq_t q);
    int s = 0;
    foreach (q[i]) s += int'(q[i]);
    return 8'(s % 256);
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit force_send = 0);
    int n = 0;
    while (!force_send && rx_rdy !== 1'b1 && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    if (!force_send) check("rx_rdy_wait", 32'(rx_rdy === 1'b1), 1);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bq_t q, input logic [7:0] chk);
    send_byte(SYNC);
    send_byte(8'(q.size()));
    foreach (q[i]) send_byte(q[i]);
    send_byte(chk);
  endtask

  task automatic expect_frame(input bq_t q);
    int    n = 0;
    beat_t b;
    while (rx_q.size() < q.size() && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    check("drain_done", 32'(rx_q.size() >= q.size()), 1);
    foreach (q[i]) begin
      if (rx_q.size() == 0) break;
      b = rx_q.pop_front();
      check("data", b.d, q[i]);
      check("last", b.l, 32'(i == q.size() - 1));
      check("len", b.n, q.size());
    end
  endtask

  task automatic check_err();
    check("err_pulses", err_seen, exp_err);
    check("err_count", err_count, (exp_err > 255) ? 255 : exp_err);
  endtask

  task automatic rand_frame();
    int         kind, n;
    logic [7:0] b;
    bq_t        q;
    repeat ($urandom_range(0, 2)) begin
      b = 8'($urandom_range(0, 255));
      if (b == SYNC) b = 8'h5A;
      send_byte(b);
    end
    kind = $urandom_range(0, 9);
    if (kind < 8) begin
      n = $urandom_range(1, MAX_LEN);
      q = {};
      repeat (n) q.push_back(8'($urandom_range(0, 255)));
      if (kind < 6) begin
        send_frame(q, sum8(q));
        expect_frame(q);
      end else begin
        send_frame(q, sum8(q) + 8'($urandom_range(1, 255)));
        exp_err++;
        check_err();
        check("no_output", rx_q.size(), 0);
      end
    end else begin
      send_byte(SYNC);
      send_byte(($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
      exp_err++;
      check_err();
    end
  endtask

  initial begin
    bq_t pl;
    bit  stable;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rdy_fix = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", valid, 0);
    check("rst_err", err, 0);
    check("rst_err_count", err_count, 0);
    check("rst_rx_rdy", rx_rdy, 1);
    check("rst_data", data, 0);
    check("rst_last", last, 0);
    check("rst_len", len, 0);
    rst_n = 1'b1;

    // basic good frame
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(pl, sum8(pl));
    expect_frame(pl);
    @(posedge clk); #1;
    check("t1_rx_rdy", rx_rdy, 1);
    check("t1_valid_low", valid, 0);
    check_err();

    // bad checksum, then a good frame
    pl = '{8'h10, 8'h20};
    send_frame(pl, 8'h00);
    exp_err++;
    check_err();
    check("t2_no_output", rx_q.size(), 0);
    pl = '{8'h5C};
    send_frame(pl, sum8(pl));
    expect_frame(pl);

    // LEN boundaries, then sync byte used as data
    send_byte(SYNC); send_byte(8'h00); exp_err++;
    send_byte(SYNC); send_byte(8'(MAX_LEN + 1)); exp_err++;
    check_err();
    send_byte(8'h12); send_byte(SYNC); send_byte(8'h01); send_byte(SYNC); send_byte(SYNC);
    pl = '{SYNC};
    expect_frame(pl);

    // MAX_LEN frame
    pl = {};
    for (int i = 0; i < MAX_LEN; i++) pl.push_back(8'(8'hF0 + i));
    send_frame(pl, sum8(pl));
    expect_frame(pl);

    // downstream stall during drain, plus a stray byte edge
    rdy_fix = 1'b0;
    pl = '{8'h7E, 8'h81};
    send_frame(pl, sum8(pl));
    check("t4_valid", valid, 1);
    check("t4_data", data, 8'h7E);
    check("t4_last", last, 0);
    check("t4_rx_rdy", rx_rdy, 0);
    stable = 1;
    repeat (20) begin
      @(posedge clk); #1;
      if (valid !== 1'b1 || data !== 8'h7E || rx_rdy !== 1'b0) stable = 0;
    end
    check("t4_stable", 32'(stable), 1);
    send_byte(8'h00, 1);
    exp_err++;
    check_err();
    check("t4_valid_kept", valid, 1);
    check("t4_data_kept", data, 8'h7E);
    rdy_fix = 1'b1;
    expect_frame(pl);

    // reset mid-payload with the receiver's valid held high across reset
    send_byte(SYNC); send_byte(8'h04); send_byte(8'h01);
    @(posedge clk); #1;
    rx_data = SYNC; rx_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_err = 0;
    repeat (4) @(posedge clk);
    #1;
    check("t5_valid", valid, 0);
    check("t5_err_count", err_count, 0);
    check("t5_rx_rdy", rx_rdy, 1);
    check("t5_err_seen", err_seen, 0);
    rx_valid = 1'b0;
    pl = '{8'h33};
    send_frame(pl, sum8(pl));
    expect_frame(pl);
    check_err();

    // stalled partial frame
    send_byte(SYNC); send_byte(8'h04); send_byte(8'h01);
    repeat (1100) @(posedge clk);
    #1;
`ifdef UART_FRAME_TIMEOUT_EN
    exp_err++;
    check_err();
    pl = '{8'h44, 8'h55};
    send_frame(pl, sum8(pl));
    expect_frame(pl);
`else
    check_err();
    send_byte(8'h02); send_byte(8'h03); send_byte(8'h04); send_byte(8'h0A);
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    expect_frame(pl);
`endif

    // randomized frames with random downstream backpressure
    rdy_rand = 1;
    repeat (25) rand_frame();
    rdy_rand = 0;
    repeat (4) @(posedge clk);
    #1;
    check_err();
    check("final_empty", rx_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
